sprite_motion_sequencer: RTL and testbench

//  Upstream command source for the pixel drawing engine that feeds vga_adapter (320x240, 12-bit colour).

---
 rtl/gfx_pkg.sv | 47 ++++
 rtl/tick_divider.sv | 27 ++
 rtl/sprite_motion_sequencer.sv | 148 ++++++++++++++
 tb/tb_sprite_motion_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared drawing-command definitions for the sprite pipeline feeding vga_adapter:
// screen/sprite geometry, command kinds, sequencer states and a command builder.
package gfx_pkg;

    localparam logic [8:0]  SCREEN_W  = 9'd320;
    localparam logic [7:0]  SCREEN_H  = 8'd240;
    localparam logic [8:0]  SPR_W     = 9'd16;
    localparam logic [7:0]  SPR_H     = 8'd16;
    localparam logic [11:0] BG_COLOUR = 12'h884;

    localparam logic CMD_FILL = 1'b0;
    localparam logic CMD_BLIT = 1'b1;

    typedef enum logic [2:0] {
        INIT_BG,
        IDLE,
        ERASE,
        MOVE,
        BLIT
    } seq_state_t;

    typedef struct packed {
        logic        kind;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [8:0]  w;
        logic [7:0]  h;
        logic [11:0] colour;
    } draw_cmd_t;

    // Fills always paint the background; blits carry no colour of their own.
    function automatic draw_cmd_t make_cmd(input logic       kind,
                                           input logic [8:0] x,
                                           input logic [7:0] y,
                                           input logic [8:0] w,
                                           input logic [7:0] h);
        draw_cmd_t c;
        c.kind   = kind;
        c.x      = x;
        c.y      = y;
        c.w      = w;
        c.h      = h;
        c.colour = (kind == CMD_FILL) ? BG_COLOUR : 12'h000;
        return c;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running down-counter that emits a one-cycle motion tick every TICK_DIV clocks.
module tick_divider #(
    parameter int TICK_DIV = 5000000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == '0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            count <= RELOAD;
        end else if (tick) begin
            count <= RELOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/sprite_motion_sequencer.sv
// Paces sprite motion from a frame tick and issues ordered FILL/BLIT draw commands
// over a valid/ready handshake, all on CLOCK_50.
module sprite_motion_sequencer
    import gfx_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int START_X  = 160,
    parameter int STEP     = 1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        enable,
    input  logic [7:0]  y_set,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_kind,
    output logic [8:0]  cmd_x,
    output logic [7:0]  cmd_y,
    output logic [8:0]  cmd_w,
    output logic [7:0]  cmd_h,
    output logic [11:0] cmd_colour,
    output logic [8:0]  sprite_x,
    output logic [7:0]  sprite_y,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [8:0] X_START = 9'(START_X);
    localparam logic [8:0] X_STEP  = 9'(STEP);
    localparam logic [7:0] Y_MAX   = SCREEN_H - SPR_H;
    localparam logic [7:0] Y_MID   = SCREEN_H >> 1;

    seq_state_t state, state_next;
    draw_cmd_t  cmd_q, cmd_next;
    logic       valid_next;
    logic [8:0] x_next;
    logic [7:0] y_next;
    logic       done_next;
    logic       tick;
    logic       tick_en;
    logic       consume;
    logic       pending;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tick     (tick)
    );

    assign tick_en = tick & enable;
    assign consume = (state == IDLE) && pending;

    // A tick landing on the consume cycle re-arms pending rather than counting as dropped.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= tick_en && pending && !consume;
            if (tick_en) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

    // Command states load their command on entry, then hold it until the engine takes it.
    always_comb begin
        state_next = state;
        cmd_next   = cmd_q;
        valid_next = cmd_valid;
        x_next     = sprite_x;
        y_next     = sprite_y;
        done_next  = 1'b0;
        unique case (state)
            INIT_BG: begin
                if (!cmd_valid) begin
                    cmd_next   = make_cmd(CMD_FILL, 9'd0, 8'd0, SCREEN_W, SCREEN_H);
                    valid_next = 1'b1;
                end else if (cmd_ready) begin
                    valid_next = 1'b0;
                    state_next = BLIT;
                end
            end
            IDLE: begin
                if (pending) begin
                    state_next = ERASE;
                end
            end
            ERASE: begin
                if (!cmd_valid) begin
                    cmd_next   = make_cmd(CMD_FILL, sprite_x, sprite_y, SPR_W, SPR_H);
                    valid_next = 1'b1;
                end else if (cmd_ready) begin
                    valid_next = 1'b0;
                    state_next = MOVE;
                end
            end
            MOVE: begin
                x_next     = (sprite_x < X_STEP) ? X_START : sprite_x - X_STEP;
                y_next     = (y_set > Y_MAX) ? Y_MAX : y_set;
                state_next = BLIT;
            end
            BLIT: begin
                if (!cmd_valid) begin
                    cmd_next   = make_cmd(CMD_BLIT, sprite_x, sprite_y, SPR_W, SPR_H);
                    valid_next = 1'b1;
                end else if (cmd_ready) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = INIT_BG;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= INIT_BG;
            cmd_q      <= '0;
            cmd_valid  <= 1'b0;
            sprite_x   <= X_START;
            sprite_y   <= Y_MID;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cmd_q      <= cmd_next;
            cmd_valid  <= valid_next;
            sprite_x   <= x_next;
            sprite_y   <= y_next;
            frame_done <= done_next;
        end
    end

    assign cmd_kind   = cmd_q.kind;
    assign cmd_x      = cmd_q.x;
    assign cmd_y      = cmd_q.y;
    assign cmd_w      = cmd_q.w;
    assign cmd_h      = cmd_q.h;
    assign cmd_colour = cmd_q.colour;

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Bench for sprite_motion_sequencer: directed scenarios plus a random-ready phase, with a
// transaction-level model of sprite position, tick pacing and frame/overrun accounting.
module tb_sprite_motion_sequencer;

    localparam int TB_TICK_DIV = 8;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        cmd_ready = 1'b1;
    logic [7:0]  y_set = 8'd120;
    logic        cmd_valid, cmd_kind, frame_done, overrun;
    logic [8:0]  cmd_x, cmd_w, sprite_x;
    logic [7:0]  cmd_y, cmd_h, sprite_y;
    logic [11:0] cmd_colour;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    int exp_phase = 0;
    int exp_x = 160;
    int exp_y = 120;
    int frames = 0;
    int overruns = 0;
    int ticks_en = 0;
    int xfers = 0;
    int wraps = 0;
    int last_tick_edge = 0;
    int last_erase_edge = 0;
    int last_blit_edge = 0;

    bit          snap_ok = 1'b0;
    logic        snap_valid = 1'b0;
    logic        snap_ready = 1'b0;
    logic [46:0] snap_cmd = '0;

    always #10 CLOCK_50 = ~CLOCK_50;

    sprite_motion_sequencer #(
        .TICK_DIV (TB_TICK_DIV),
        .START_X  (160),
        .STEP     (1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .enable     (enable),
        .y_set      (y_set),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    function automatic logic [46:0] pack(input logic k, input logic [8:0] x, input logic [7:0] y,
                                         input logic [8:0] w, input logic [7:0] h,
                                         input logic [11:0] c);
        return {k, x, y, w, h, c};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Posedges since reset release; the divider reaches zero on every 8th cycle.
    always @(posedge CLOCK_50) edge_n <= resetn ? edge_n + 1 : 0;

    // Transfer monitor and scoreboard: a snapshot with valid & ready taken at one negedge
    // is a transfer on the following posedge unless reset intervened.
    always @(negedge CLOCK_50 or negedge resetn) begin
        logic [46:0] cur;
        logic [46:0] exp_cmd;
        bit          was_blit;
        if (!resetn) begin
            snap_ok = 1'b0;
            exp_phase = 0;
            exp_x = 160;
            exp_y = 120;
            frames = 0;
            overruns = 0;
            ticks_en = 0;
            xfers = 0;
            wraps = 0;
        end else begin
            cur = pack(cmd_kind, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour);
            was_blit = 1'b0;
            if (snap_ok && snap_valid && snap_ready) begin
                xfers++;
                if (exp_phase == 0) begin
                    exp_cmd = pack(1'b0, 9'd0, 8'd0, 9'd320, 8'd240, 12'h884);
                    exp_phase = 1;
                end else if (exp_phase == 1) begin
                    exp_cmd = pack(1'b1, 9'(exp_x), 8'(exp_y), 9'd16, 8'd16, 12'h000);
                    exp_phase = 2;
                    was_blit = 1'b1;
                    last_blit_edge = edge_n;
                end else begin
                    exp_cmd = pack(1'b0, 9'(exp_x), 8'(exp_y), 9'd16, 8'd16, 12'h884);
                    last_erase_edge = edge_n;
                    if (exp_x == 0) begin
                        exp_x = 160;
                        wraps++;
                    end else begin
                        exp_x = exp_x - 1;
                    end
                    exp_y = (y_set > 8'd224) ? 224 : int'(y_set);
                    exp_phase = 1;
                end
                check_output("cmd_transfer", 64'(snap_cmd), 64'(exp_cmd));
            end
            if (snap_ok && snap_valid && !snap_ready) begin
                check_output("stall_valid", 64'(cmd_valid), 64'd1);
                check_output("stall_cmd", 64'(cur), 64'(snap_cmd));
            end
            check_output("frame_done", 64'(frame_done), 64'(was_blit));
            if (frame_done) frames++;
            if (overrun) overruns++;
            if ((edge_n % TB_TICK_DIV) == TB_TICK_DIV - 1 && enable) begin
                ticks_en++;
                last_tick_edge = edge_n;
            end
            snap_valid = cmd_valid;
            snap_ready = cmd_ready;
            snap_cmd = cur;
            snap_ok = 1'b1;
        end
    end

    task automatic drain();
        enable = 1'b0;
        cmd_ready = 1'b1;
        apply_stimulus(30);
    endtask

    task automatic check_accounting(input string tag);
        // Every enabled tick either produces a frame or is dropped; reset adds the initial frame.
        check_output(tag, 64'(frames + overruns), 64'(ticks_en + 1));
        check_output("idle_valid", 64'(cmd_valid), 64'd0);
    endtask

    task automatic wait_one_tick(output bit ok);
        int t0;
        t0 = ticks_en;
        ok = 1'b0;
        for (int i = 0; i < 3 * TB_TICK_DIV; i++) begin
            apply_stimulus(1);
            if (ticks_en != t0) begin
                ok = 1'b1;
                break;
            end
        end
        enable = 1'b0;
    endtask

    task automatic wait_cmd(input logic kind, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLOCK_50);
            if (cmd_valid === 1'b1 && cmd_kind === kind) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int f0, o0, t0, x0;

        $display("[TB] reset and background fill");
        apply_stimulus(3);
        check_output("rst_valid", 64'(cmd_valid), 64'd0);
        check_output("rst_cmd", 64'(pack(cmd_kind, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour)), 64'd0);
        check_output("rst_sprite_x", 64'(sprite_x), 64'd160);
        check_output("rst_sprite_y", 64'(sprite_y), 64'd120);
        check_output("rst_pulses", 64'({frame_done, overrun}), 64'd0);
        resetn = 1'b1;
        apply_stimulus(1);
        check_output("init_valid", 64'(cmd_valid), 64'd1);
        apply_stimulus(10);
        check_output("init_frames", 64'(frames), 64'd1);
        check_output("init_xfers", 64'(xfers), 64'd2);
        check_output("init_idle", 64'(cmd_valid), 64'd0);

        $display("[TB] single tick, y_set = 50");
        y_set = 8'd50;
        enable = 1'b1;
        wait_one_tick(ok);
        check_output("tick_wait", 64'(ok), 64'd1);
        apply_stimulus(20);
        check_output("move_x", 64'(sprite_x), 64'd159);
        check_output("move_y", 64'(sprite_y), 64'd50);
        // Tick cycle -> pending -> consume, then ERASE transfer 2 edges later, BLIT 5 edges after consume.
        check_output("erase_latency", 64'(last_erase_edge - last_tick_edge), 64'd4);
        check_output("frame_latency", 64'(last_blit_edge - last_tick_edge), 64'd7);
        check_accounting("acct_single");

        $display("[TB] run to wrap with y clamp");
        y_set = 8'd250;
        enable = 1'b1;
        for (int i = 0; i < 2400 && wraps == 0; i++) apply_stimulus(1);
        check_output("wrap_seen", 64'(wraps > 0), 64'd1);
        drain();
        check_output("clamp_y", 64'(sprite_y), 64'd224);
        check_output("wrap_x", 64'(sprite_x), 64'(exp_x));
        check_accounting("acct_wrap");

        $display("[TB] stall during erase");
        f0 = frames;
        o0 = overruns;
        t0 = ticks_en;
        cmd_ready = 1'b0;
        enable = 1'b1;
        wait_cmd(1'b0, 3 * TB_TICK_DIV, ok);
        check_output("erase_wait", 64'(ok), 64'd1);
        x0 = xfers;
        apply_stimulus(20);
        check_output("stall_no_xfer", 64'(xfers), 64'(x0));
        cmd_ready = 1'b1;
        enable = 1'b0;
        apply_stimulus(30);
        check_output("stall_frames", 64'(frames - f0), 64'd2);
        check_output("stall_overruns", 64'(overruns - o0), 64'((ticks_en - t0) - 2));
        check_accounting("acct_stall");

        $display("[TB] random ready");
        y_set = 8'($urandom_range(0, 255));
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            apply_stimulus(1);
        end
        drain();
        check_output("rand_x", 64'(sprite_x), 64'(exp_x));
        check_output("rand_y", 64'(sprite_y), 64'(exp_y));
        check_accounting("acct_random");

        $display("[TB] enable low, then enable mid-count");
        x0 = xfers;
        o0 = overruns;
        apply_stimulus(40);
        check_output("disabled_xfers", 64'(xfers), 64'(x0));
        check_output("disabled_overrun", 64'(overruns), 64'(o0));
        for (int i = 0; i < TB_TICK_DIV && (edge_n % TB_TICK_DIV) != 3; i++) apply_stimulus(1);
        enable = 1'b1;
        wait_one_tick(ok);
        check_output("midcount_tick", 64'(ok), 64'd1);
        check_output("midcount_quiet", 64'(xfers), 64'(x0));
        apply_stimulus(20);
        check_output("midcount_erase", 64'(last_erase_edge - last_tick_edge), 64'd4);
        check_output("midcount_xfers", 64'(xfers - x0), 64'd2);
        check_accounting("acct_midcount");

        $display("[TB] reset during blit");
        enable = 1'b1;
        wait_cmd(1'b1, 3 * TB_TICK_DIV, ok);
        check_output("blit_wait", 64'(ok), 64'd1);
        #2;
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        check_output("async_valid", 64'(cmd_valid), 64'd0);
        check_output("async_cmd", 64'(pack(cmd_kind, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour)), 64'd0);
        check_output("async_sprite", 64'({sprite_x, sprite_y}), 64'({9'd160, 8'd120}));
        check_output("async_pulses", 64'({frame_done, overrun}), 64'd0);
        apply_stimulus(2);
        resetn = 1'b1;
        apply_stimulus(1);
        check_output("reinit_valid", 64'(cmd_valid), 64'd1);
        apply_stimulus(10);
        check_output("reinit_xfers", 64'(xfers), 64'd2);
        check_output("reinit_frames", 64'(frames), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
